// File: rtl/seq_detect_prog_if.sv
// Serial-bit / match-result bundle for seq_detect_prog.
// SEQ_DET_MASK_EN adds the mask_in field.
interface seq_detect_prog_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               x;
    logic               load;
    logic [PAT_LEN-1:0] pattern_in;
    logic               overlap_in;
    logic               clr_count;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0] mask_in;
`endif
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    modport master (
        output en, x, load, pattern_in, overlap_in, clr_count,
`ifdef SEQ_DET_MASK_EN
        output mask_in,
`endif
        input  z, match_count, count_sat
    );

    modport slave (
        input  en, x, load, pattern_in, overlap_in, clr_count,
`ifdef SEQ_DET_MASK_EN
        input  mask_in,
`endif
        output z, match_count, count_sat
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: shift register + comparator.
// Define SEQ_DET_MASK_EN to add a loadable don't-care mask.
module seq_detect_prog #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b0110),
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_detect_prog_if.slave bus
);
    localparam int                FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]     FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CMAX = '1;

    logic [PAT_LEN-1:0] pat_q;
    logic               ovl_q;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic               z_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0] mask_q;
`endif

    logic [PAT_LEN-1:0] nxt;
    logic [FW-1:0]      fill_nxt;
    logic               hit;
    logic               match;

    always_comb begin
        nxt      = {hist[PAT_LEN-2:0], bus.x};
        fill_nxt = (fill == FULL) ? FULL : fill + FW'(1);
`ifdef SEQ_DET_MASK_EN
        hit      = ((nxt ^ pat_q) & mask_q) == '0;
`else
        hit      = (nxt == pat_q);
`endif
        match    = bus.en && !bus.load && (fill_nxt == FULL) && hit;
    end

    // load wins over en; the bit presented with a load is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= RESET_PAT;
            ovl_q  <= 1'b1;
            hist   <= '0;
            fill   <= '0;
            z_q    <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q <= '1;
`endif
        end else if (bus.load) begin
            pat_q  <= bus.pattern_in;
            ovl_q  <= bus.overlap_in;
            hist   <= '0;
            fill   <= '0;
            z_q    <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q <= bus.mask_in;
`endif
        end else if (bus.en) begin
            z_q <= match;
            if (match && !ovl_q) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= nxt;
                fill <= fill_nxt;
            end
        end else begin
            z_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (bus.clr_count) begin
            cnt_q <= match ? CNT_W'(1) : '0;
            sat_q <= 1'b0;
        end else if (match) begin
            if (cnt_q != CMAX)
                cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q >= CMAX - CNT_W'(1))
                sat_q <= 1'b1;
        end
    end

    assign bus.z           = z_q;
    assign bus.match_count = cnt_q;
    assign bus.count_sat   = sat_q;
endmodule
